// File: rtl/regfile_scoreboard_pkg.sv
// Shared RISC-V core types for the integer register file: register tag,
// data word and the hardwired-zero register index.
package regfile_scoreboard_pkg;

    localparam int RV_NUM_REGS = 32;
    localparam int RV_XLEN     = 32;
    localparam int RV_TAG_W    = $clog2(RV_NUM_REGS);

    typedef logic [RV_TAG_W-1:0] tag_t;
    typedef logic [RV_XLEN-1:0]  word_t;

    localparam tag_t ZERO_TAG = '0;

endpackage

// File: rtl/regfile_scoreboard_pending_counter.sv
// Per-register pending-write counter. clr wins over inc/dec; inc and dec in
// the same cycle cancel; the count never wraps in either direction.
module regfile_pending_counter #(
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              dec,
    input  logic              clr,
    output logic [PEND_W-1:0] count,
    output logic [PEND_W-1:0] count_next,
    output logic              saturated
);

    typedef logic [PEND_W-1:0] pend_t;
    localparam pend_t PEND_MAX = '1;

    pend_t count_q;
    pend_t count_d;

    // Next count: flush clears, otherwise a lone inc or dec moves the count.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && !dec && (count_q != PEND_MAX)) begin
            count_d = count_q + pend_t'(1);
        end else if (dec && !inc && (count_q != '0)) begin
            count_d = count_q - pend_t'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count      = count_q;
    assign count_next = count_d;
    assign saturated  = (count_q == PEND_MAX);

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with a per-register pending-write scoreboard.
// Decode reads operands and issues destinations; writeback retires them.
// Optional build macro REGFILE_SCOREBOARD_BYPASS_EN forwards the retiring
// writeback value and readiness to read ports in the same cycle.
//
// Handshake: issue_valid is accepted on a clock edge only when issue_stall
// is low in that cycle (and flush is low); wb_valid is always accepted.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int NUM_REGS = RV_NUM_REGS,
    parameter int DATA_W   = RV_XLEN,
    parameter int NUM_READ = 2,
    parameter int PEND_W   = 2,
    parameter int TAG_W    = $clog2(NUM_REGS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_READ*TAG_W-1:0]    rd_tag,
    output logic [NUM_READ*DATA_W-1:0]   rd_data,
    output logic [NUM_READ-1:0]          rd_ready,
    input  logic                         issue_valid,
    input  logic [TAG_W-1:0]             issue_tag,
    output logic                         issue_stall,
    input  logic                         wb_valid,
    input  logic [TAG_W-1:0]             wb_tag,
    input  logic [DATA_W-1:0]            wb_data,
    input  logic                         flush,
    output logic [$clog2(NUM_REGS):0]    busy_count
);

    localparam int BUSY_W    = $clog2(NUM_REGS) + 1;
    localparam int TAG_SPACE = 1 << TAG_W;

    typedef logic [PEND_W-1:0] pend_t;

    logic [DATA_W-1:0] reg_q [NUM_REGS];
    logic [DATA_W-1:0] reg_d [NUM_REGS];
    logic [BUSY_W-1:0] busy_q;
    logic [BUSY_W-1:0] busy_d;

    pend_t cnt_w      [NUM_REGS];
    pend_t cnt_next_w [NUM_REGS];
    logic [NUM_REGS-1:0] sat_w;

    // Lookup vectors over the full tag space so out-of-range and zero tags
    // fall back to "not writable, always ready".
    logic [TAG_SPACE-1:0] tag_valid;
    logic [TAG_SPACE-1:0] sat_v;
    logic [TAG_SPACE-1:0] zero_v;
`ifdef REGFILE_SCOREBOARD_BYPASS_EN
    logic [TAG_SPACE-1:0] one_v;
`endif
    logic [NUM_REGS-1:0]  nz_next_v;

    logic issue_ok;
    logic issue_fire;

    assign cnt_w[0]      = '0;
    assign cnt_next_w[0] = '0;
    assign sat_w[0]      = 1'b0;
    assign nz_next_v[0]  = 1'b0;

    genvar g;
    generate
        for (g = 1; g < NUM_REGS; g++) begin : g_cnt
            regfile_pending_counter #(.PEND_W(PEND_W)) u_cnt (
                .clk        (clk),
                .reset      (reset),
                .inc        (issue_fire && (issue_tag == TAG_W'(g))),
                .dec        (wb_valid && (wb_tag == TAG_W'(g))),
                .clr        (flush),
                .count      (cnt_w[g]),
                .count_next (cnt_next_w[g]),
                .saturated  (sat_w[g])
            );
            assign nz_next_v[g] = (cnt_next_w[g] != '0);
        end

        for (g = 0; g < TAG_SPACE; g++) begin : g_lut
            if ((g > 0) && (g < NUM_REGS)) begin : g_live
                assign tag_valid[g] = 1'b1;
                assign sat_v[g]     = sat_w[g];
                assign zero_v[g]    = (cnt_w[g] == '0);
`ifdef REGFILE_SCOREBOARD_BYPASS_EN
                assign one_v[g]     = (cnt_w[g] == pend_t'(1));
`endif
            end else begin : g_dead
                assign tag_valid[g] = 1'b0;
                assign sat_v[g]     = 1'b0;
                assign zero_v[g]    = 1'b1;
`ifdef REGFILE_SCOREBOARD_BYPASS_EN
                assign one_v[g]     = 1'b0;
`endif
            end
        end
    endgenerate

    // Issue stalls on a full counter unless a same-tag retire frees a slot.
    always_comb begin
        issue_ok    = issue_valid && tag_valid[issue_tag];
        issue_stall = issue_ok && sat_v[issue_tag] &&
                      !(wb_valid && (wb_tag == issue_tag));
        issue_fire  = issue_ok && !issue_stall;
    end

    // Combinational read ports: array data plus pending-count readiness.
    always_comb begin
        rd_data  = '0;
        rd_ready = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            logic [TAG_W-1:0] t;
            t = rd_tag[i*TAG_W +: TAG_W];
            if (tag_valid[t]) begin
                rd_data[i*DATA_W +: DATA_W] = reg_q[t];
            end
            rd_ready[i] = zero_v[t];
`ifdef REGFILE_SCOREBOARD_BYPASS_EN
            if (tag_valid[t] && wb_valid && (wb_tag == t)) begin
                rd_data[i*DATA_W +: DATA_W] = wb_data;
                if (one_v[t] && !(issue_valid && (issue_tag == t))) begin
                    rd_ready[i] = 1'b1;
                end
            end
`endif
        end
    end

    // Writeback updates the addressed register; register 0 is never written.
    always_comb begin
        for (int j = 0; j < NUM_REGS; j++) begin
            reg_d[j] = reg_q[j];
            if ((j != 0) && wb_valid && (wb_tag == TAG_W'(j))) begin
                reg_d[j] = wb_data;
            end
        end
        reg_d[0] = '0;
    end

    // Busy count tracks the counters as they will be after this edge.
    always_comb begin
        busy_d = '0;
        for (int j = 0; j < NUM_REGS; j++) begin
            busy_d = busy_d + BUSY_W'(nz_next_v[j]);
        end
    end

    // Register array and busy count, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < NUM_REGS; j++) begin
                reg_q[j] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int j = 0; j < NUM_REGS; j++) begin
                reg_q[j] <= reg_d[j];
            end
            busy_q <= busy_d;
        end
    end

    assign busy_count = busy_q;

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised integer register file with a per-register pending-write scoreboard, for the pipelined RISC-V core.
- Replaces the fixed 2-read/1-write array in decode. Adds N read ports, hazard detection (rd_ready), issue stall and pipeline flush.
- Sits between decode (read/issue) and writeback (write/retire).

Parameters:
- NUM_REGS, 32, number of architectural registers; index 0 is hardwired zero.
- DATA_W, 32, register width in bits.
- NUM_READ, 2, number of read ports.
- PEND_W, 2, width of the per-register pending counter; max outstanding writes per register = 2^PEND_W-1.
- TAG_W, $clog2(NUM_REGS), register index width (derived; do not override).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- rd_tag  in  NUM_READ*TAG_W  read register indices, port i at bits [i*TAG_W +: TAG_W]
- rd_data  out  NUM_READ*DATA_W  read data per port
- rd_ready  out  NUM_READ  1 = port's register has no pending write (operand usable)
- issue_valid  in  1  decode issues an instruction that will write issue_tag
- issue_tag  in  TAG_W  destination register of the issued instruction
- issue_stall  out  1  issue_tag counter saturated; issue must be held
- wb_valid  in  1  writeback retires a register write
- wb_tag  in  TAG_W  writeback destination
- wb_data  in  DATA_W  writeback value
- flush  in  1  discard all pending writes (branch redirect)
- busy_count  out  $clog2(NUM_REGS)+1  number of registers with nonzero pending count

Behaviour:
- Reset: all registers 0, all pending counters 0; rd_ready all 1, issue_stall 0, busy_count 0. rd_data reflects zeroed registers. Reset overrides issue, wb and flush in the same cycle.
- Register 0:
  - Reads always return 0 with rd_ready=1.
  - Writes, issues and retirements to tag 0 are ignored; its counter never changes.
- Read: combinational from the array and pending counters (zero-cycle latency).
- Write: on a clk edge with wb_valid && wb_tag!=0, reg[wb_tag] <= wb_data.
- Pending counter per register:
  - Increments on issue_valid && !issue_stall && issue_tag!=0.
  - Decrements on wb_valid && wb_tag!=0 && count>0.
  - Issue and writeback to the same tag in the same cycle: count unchanged.
  - Writeback when count==0: data is written, counter stays 0 (no underflow).
- issue_stall = issue_valid && issue_tag!=0 && count[issue_tag]==2^PEND_W-1 && !(wb_valid && wb_tag==issue_tag). A same-cycle retire frees a slot.
- rd_ready[i] = (count[rd_tag[i]]==0), subject to bypass (see Optional Feature).
- flush:
  - Clears every pending counter to 0 on the clk edge.
  - A wb in the same cycle still writes data.
  - An issue in the same cycle is dropped: flush wins over issue.
- busy_count: registered population count of nonzero counters, updated every edge.
- Out-of-range tags (>= NUM_REGS): reads return 0 with rd_ready=1; writes and issues are ignored.

Optional Feature:
- Macro: REGFILE_SCOREBOARD_BYPASS_EN.
- Defined:
  - A read port whose rd_tag==wb_tag (nonzero) while wb_valid returns wb_data combinationally.
  - rd_ready is 1 if count==1, a writeback is retiring that tag, and no same-cycle issue to it.
- Undefined:
  - Reads return array contents only.
  - rd_ready waits until the counter reaches 0 on the following cycle.

Decomposition:
- Shared riscv package: tag typedef, word typedef, zero_tag constant.
- Pending-counter typedef (logic [PEND_W-1:0]) local to the module.
- Natural sub-module: regfile_pending_counter. One instance per register; inputs inc, dec, clr; outputs count and saturated; instantiated in a generate loop for indices 1..NUM_REGS-1.

Test Plan:
- Reset, then read tags 0 and 5 -> rd_data 0/0, rd_ready 1/1, busy_count 0.
- Issue tag 5; next cycle read 5 -> rd_ready 0, busy_count 1. Then wb tag 5 with 0xDEADBEEF.
  - Bypass on: same-cycle rd_data=0xDEADBEEF, rd_ready=1.
  - Bypass off: both visible only the next cycle.
- Issue tag 7 three times (PEND_W=2) -> counter 3. Fourth issue -> issue_stall=1, counter stays 3. Fourth issue with simultaneous wb tag 7 -> stall=0, counter stays 3.
- Issue tags 3 and 4, then flush with simultaneous issue of tag 9 and wb of tag 3 (0x12) -> all counters 0, busy_count 0, reg3=0x12, tag 9 not pending.
- wb tag 0 with 0xFFFFFFFF, issue tag 0 -> read tag 0 gives 0, rd_ready 1, issue_stall 0, busy_count 0.
- Assert reset while tags 2 and 6 are pending and reg2=0x55 -> next cycle all counters 0, reg2 reads 0, busy_count 0.
